// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier datapath.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = DEF_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth window {mplier[1:0], extra} codes as seen by the control unit
  localparam logic [2:0] BOOTH_000 = 3'b000;
  localparam logic [2:0] BOOTH_001 = 3'b001;
  localparam logic [2:0] BOOTH_010 = 3'b010;
  localparam logic [2:0] BOOTH_011 = 3'b011;
  localparam logic [2:0] BOOTH_100 = 3'b100;
  localparam logic [2:0] BOOTH_101 = 3'b101;
  localparam logic [2:0] BOOTH_110 = 3'b110;
  localparam logic [2:0] BOOTH_111 = 3'b111;

endpackage

// File: rtl/mult_addsub.sv
// Combinational W-bit adder/subtractor: sum = sub ? a - b : a + b.
module mult_addsub #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Two's complement subtract folded into the single carry chain
  assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/mult_booth_datapath.sv
// Radix-4 Booth multiplier datapath steered by an external control unit via booth_bits.
// Define MULT_OVF_DETECT_EN to report signed overflow of the WIDTH-bit product on data_exception.
module mult_booth_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             add,
  input  logic             sub,
  input  logic             shift_mcand,
  input  logic             shift_prod,
  input  logic             nop,
  output logic [2:0]       booth_bits,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int AW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 3;
  localparam int SW = $clog2(STEPS + 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic [AW-1:0]    mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic             extra_reg, extra_next;
  logic [SW-1:0]    step_reg, step_next, step_inc;

  logic [AW-1:0]    addend, addsub_sum, sum;
  logic signed [PW-1:0] p_cat, p_shift;
  logic [AW-1:0]    shift_acc;
  logic [WIDTH-1:0] shift_mplier;
  logic             shift_extra;
  logic             do_arith, last_step;
  logic             unused_nop;

  // nop carries no datapath meaning; idle cycles are implied by !add && !sub
  assign unused_nop = nop;

  assign addend   = shift_mcand ? {mcand_reg[AW-2:0], 1'b0} : mcand_reg;
  assign do_arith = add ^ sub;

  mult_addsub #(.W(AW)) u_addsub (
    .a   (acc_reg),
    .b   (addend),
    .sub (sub),
    .sum (addsub_sum)
  );

  assign sum          = do_arith ? addsub_sum : acc_reg;
  assign p_cat        = {sum, mplier_reg, extra_reg};
  assign p_shift      = p_cat >>> 2;
  assign shift_acc    = p_shift[PW-1 -: AW];
  assign shift_mplier = p_shift[WIDTH:1];
  assign shift_extra  = p_shift[0];
  assign step_inc     = step_reg + SW'(1);
  assign last_step    = (state_reg == RUN) && shift_prod && !start && (step_inc == SW'(STEPS));

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    extra_next  = extra_reg;
    step_next   = step_reg;
    if (start) begin
      // start always wins, aborting any operation in flight
      state_next  = RUN;
      acc_next    = '0;
      mcand_next  = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      mplier_next = data_operandB;
      extra_next  = 1'b0;
      step_next   = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (shift_prod) begin
            acc_next    = shift_acc;
            mplier_next = shift_mplier;
            extra_next  = shift_extra;
            step_next   = step_inc;
            if (last_step) state_next = DONE;
          end else begin
            acc_next = sum;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      extra_reg  <= 1'b0;
      step_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      extra_reg  <= extra_next;
      step_reg   <= step_next;
    end
  end

  assign booth_bits     = {mplier_reg[1:0], extra_reg};
  assign data_result    = mplier_reg;
  assign data_resultRDY = (state_reg == DONE);
  assign busy           = (state_reg == RUN);

`ifdef MULT_OVF_DETECT_EN
  logic [AW-1:0] ovf_bits;
  logic          exc_reg;

  // Product fits in WIDTH signed bits only if every acc bit copies the result sign
  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_ovf
      assign ovf_bits[gi] = shift_acc[gi] ^ shift_mplier[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exc_reg <= 1'b0;
    end else if (start) begin
      exc_reg <= 1'b0;
    end else if (last_step) begin
      exc_reg <= |ovf_bits;
    end
  end

  assign data_exception = exc_reg;
`else
  assign data_exception = 1'b0;
`endif

endmodule
